// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a small FIFO, issues them one at a
// time to a downstream ALU, waits for its result (or gives up after a bounded
// number of cycles) and presents exactly one response per issued command.
module alu_cmd_sequencer #(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [2:0]                     cmd_op,
  input  logic signed [N-1:0]            cmd_a,
  input  logic signed [N-1:0]            cmd_b,
  output logic [2:0]                     alu_op,
  output logic [N-1:0]                   alu_a,
  output logic [N-1:0]                   alu_b,
  input  logic signed [2*N-1:0]          alu_result,
  input  logic                           alu_valid,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic signed [2*N-1:0]          rsp_result,
  output logic [2:0]                     rsp_op,
  output logic                           rsp_timeout,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        next_state;

  logic [2:0]    fifo_op [DEPTH];
  logic [N-1:0]  fifo_a  [DEPTH];
  logic [N-1:0]  fifo_b  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] timer;

  logic push;
  logic pop;
  logic capture_ok;
  logic capture_to;
  logic timer_clr;
  logic timer_inc;

  // Acceptance depends only on the registered occupancy, never on a same-cycle pop.
  assign cmd_ready = (count < FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; ISSUE deliberately ignores alu_valid so a stale valid from the previous op cannot be captured.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture_ok = 1'b0;
    capture_to = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (alu_valid) begin
          capture_ok = 1'b1;
          next_state = RESP;
        end else if (timer == TIMER_LAST) begin
          capture_to = 1'b1;
          next_state = RESP;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FIFO storage; entries need no reset because only slots counted by count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= cmd_op;
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
    end
  end

  // Pointers wrap naturally at DEPTH (a power of two); simultaneous push and pop keep count steady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // ALU operand registers change only when a command is popped and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (pop) begin
      alu_op <= fifo_op[rd_ptr];
      alu_a  <= fifo_a[rd_ptr];
      alu_b  <= fifo_b[rd_ptr];
    end
  end

  // WAIT cycle counter, restarted for every issued command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (timer_inc) begin
      timer <= timer + 1'b1;
    end
  end

  // Response registers are loaded once when leaving WAIT and held stable through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else if (capture_ok) begin
      rsp_result  <= alu_result;
      rsp_op      <= alu_op;
      rsp_timeout <= 1'b0;
    end else if (capture_to) begin
      rsp_result  <= '0;
      rsp_op      <= alu_op;
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scenarios plus a randomized run against a
// transaction-level model of the sequencer (command queue, one command in
// flight, ALU result or timeout, one response per command).
module tb_alu_cmd_sequencer;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  typedef enum {ALU_NEVER, ALU_ALWAYS, ALU_DELAY, ALU_RANDOM} alu_mode_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } cmd_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic signed [N-1:0]    cmd_a;
  logic signed [N-1:0]    cmd_b;
  logic [2:0]             alu_op;
  logic [N-1:0]           alu_a;
  logic [N-1:0]           alu_b;
  logic signed [2*N-1:0]  alu_result;
  logic                   alu_valid;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic signed [2*N-1:0]  rsp_result;
  logic [2:0]             rsp_op;
  logic                   rsp_timeout;
  logic                   busy;
  logic [CW-1:0]          count;

  int checks = 0;
  int errors = 0;

  alu_mode_t alu_mode  = ALU_NEVER;
  int        alu_delay = 0;

  // Model state.
  cmd_t         mdl_q[$];
  bit           mdl_have_cur   = 1'b0;
  bit           mdl_presenting = 1'b0;
  cmd_t         mdl_cur        = '0;
  int           mdl_age        = 0;
  logic [7:0]   mdl_result     = '0;
  logic         mdl_timeout    = 1'b0;
  logic [2:0]   mdl_rsp_op     = '0;
  logic [2:0]   mdl_alu_op     = '0;
  logic [N-1:0] mdl_alu_a      = '0;
  logic [N-1:0] mdl_alu_b      = '0;

  // Response monitor state.
  int         rsp_seen = 0;
  logic [2:0] rsp_ops[$];

  int edges;
  int base;

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_valid  (alu_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour on sign-extended operands.
  function automatic logic [2*N-1:0] aluModel(input logic [2:0] op, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    logic signed [2*N-1:0] sa;
    logic signed [2*N-1:0] sb;
    sa = {{N{a[N-1]}}, a};
    sb = {{N{b[N-1]}}, b};
    case (op)
      3'd0:    return sa + sb;
      3'd1:    return sa - sb;
      3'd2:    return sa * sb;
      3'd3:    return sa & sb;
      default: return sa ^ sb;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  task automatic boundExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Push one command; called at a negedge with room in the FIFO, returns at the negedge after the push edge.
  task automatic applyStimulus(input logic [2:0] op, input logic signed [N-1:0] a,
                               input logic signed [N-1:0] b);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count rising edges until rsp_valid is seen.
  task automatic waitRsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) boundExpired("wait_rsp");
  endtask

  task automatic consumeRsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || count != '0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy || count != '0) boundExpired("wait_idle");
  endtask

  // Transaction-level model: queue of accepted commands, at most one in flight,
  // in-flight age 0 is the issue cycle, ages 1..TIMEOUT are wait cycles.
  always @(posedge clk or negedge rst) begin : model_step
    int   size_before;
    bit   accept_now;
    cmd_t new_cmd;
    if (!rst) begin
      mdl_q.delete();
      mdl_have_cur   = 1'b0;
      mdl_presenting = 1'b0;
      mdl_age        = 0;
      mdl_result     = '0;
      mdl_timeout    = 1'b0;
      mdl_rsp_op     = '0;
      mdl_alu_op     = '0;
      mdl_alu_a      = '0;
      mdl_alu_b      = '0;
    end else begin
      size_before = mdl_q.size();
      accept_now  = cmd_valid && (size_before < DEPTH);
      if (mdl_have_cur) begin
        if (mdl_presenting) begin
          if (rsp_ready) begin
            mdl_have_cur   = 1'b0;
            mdl_presenting = 1'b0;
          end
        end else begin
          if (mdl_age >= 1) begin
            if (alu_valid) begin
              mdl_presenting = 1'b1;
              mdl_result     = aluModel(mdl_cur.op, mdl_cur.a, mdl_cur.b);
              mdl_timeout    = 1'b0;
              mdl_rsp_op     = mdl_cur.op;
            end else if (mdl_age == TIMEOUT) begin
              mdl_presenting = 1'b1;
              mdl_result     = '0;
              mdl_timeout    = 1'b1;
              mdl_rsp_op     = mdl_cur.op;
            end
          end
          mdl_age++;
        end
      end else if (size_before > 0) begin
        mdl_cur      = mdl_q.pop_front();
        mdl_have_cur = 1'b1;
        mdl_age      = 0;
        mdl_alu_op   = mdl_cur.op;
        mdl_alu_a    = mdl_cur.a;
        mdl_alu_b    = mdl_cur.b;
      end
      if (accept_now) begin
        new_cmd.op = cmd_op;
        new_cmd.a  = cmd_a;
        new_cmd.b  = cmd_b;
        mdl_q.push_back(new_cmd);
      end
    end
  end

  // ALU stand-in: result follows the issued operands, valid depends on the selected mode.
  always @(negedge clk) begin
    case (alu_mode)
      ALU_NEVER:  alu_valid = 1'b0;
      ALU_ALWAYS: alu_valid = 1'b1;
      ALU_DELAY:  alu_valid = mdl_have_cur && !mdl_presenting && (mdl_age == alu_delay + 1);
      default:    alu_valid = ($urandom_range(0, 2) == 0);
    endcase
    alu_result = alu_valid ? aluModel(alu_op, alu_a, alu_b) : (2*N)'($urandom);
  end

  // Compare DUT against the model every cycle, well away from both edges.
  always @(negedge clk) begin
    #2;
    checkOutput("count", 32'(count), 32'(mdl_q.size()));
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(mdl_q.size() < DEPTH));
    checkOutput("busy", 32'(busy), 32'(mdl_have_cur));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(mdl_presenting));
    checkOutput("alu_op", 32'(alu_op), 32'(mdl_alu_op));
    checkOutput("alu_a", 32'(alu_a), 32'(mdl_alu_a));
    checkOutput("alu_b", 32'(alu_b), 32'(mdl_alu_b));
    if (mdl_presenting) begin
      checkOutput("rsp_result", 32'($unsigned(rsp_result)), 32'(mdl_result));
      checkOutput("rsp_op", 32'(rsp_op), 32'(mdl_rsp_op));
      checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(mdl_timeout));
    end
  end

  // Record every response handshake that is about to complete.
  always @(negedge clk) begin
    #1;
    if (rst && rsp_valid && rsp_ready) begin
      rsp_seen++;
      rsp_ops.push_back(rsp_op);
    end
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    alu_valid = 1'b0;
    alu_result = '0;

    // Reset values and reference ALU pins.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_result", 32'($unsigned(rsp_result)), 32'd0);
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("model_add", 32'(aluModel(3'd0, 4'd3, 4'd2)), 32'h05);
    checkOutput("model_mul", 32'(aluModel(3'd2, 4'hD, 4'hE)), 32'h06);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Minimum latency: add 3+2.
    $display("[TB] scenario: minimum latency");
    alu_mode = ALU_ALWAYS;
    base = rsp_seen;
    applyStimulus(3'b000, 4'sd3, 4'sd2);
    waitRsp(edges);
    checkOutput("lat_edges", 32'(edges), 32'd3);
    checkOutput("lat_result", 32'($unsigned(rsp_result)), 32'h05);
    checkOutput("lat_op", 32'(rsp_op), 32'd0);
    checkOutput("lat_timeout", 32'(rsp_timeout), 32'd0);
    consumeRsp();
    repeat (3) @(negedge clk);
    checkOutput("lat_one_rsp", 32'(rsp_seen - base), 32'd1);

    // Delayed ALU: multiply -3 * -2 after four idle wait cycles.
    $display("[TB] scenario: delayed result");
    alu_mode  = ALU_DELAY;
    alu_delay = 4;
    base = rsp_seen;
    applyStimulus(3'b010, -4'sd3, -4'sd2);
    waitRsp(edges);
    checkOutput("dly_edges", 32'(edges), 32'd7);
    checkOutput("dly_result", 32'($unsigned(rsp_result)), 32'h06);
    checkOutput("dly_op", 32'(rsp_op), 32'd2);
    consumeRsp();
    repeat (4) @(negedge clk);
    checkOutput("dly_one_rsp", 32'(rsp_seen - base), 32'd1);

    // Timeout, then a normal command.
    $display("[TB] scenario: timeout");
    alu_mode = ALU_NEVER;
    applyStimulus(3'b001, 4'sd5, 4'sd1);
    waitRsp(edges);
    checkOutput("to_edges", 32'(edges), 32'd18);
    checkOutput("to_flag", 32'(rsp_timeout), 32'd1);
    checkOutput("to_result", 32'($unsigned(rsp_result)), 32'd0);
    checkOutput("to_op", 32'(rsp_op), 32'd1);
    consumeRsp();
    alu_mode = ALU_ALWAYS;
    applyStimulus(3'b000, 4'sd1, 4'sd1);
    waitRsp(edges);
    checkOutput("after_to_edges", 32'(edges), 32'd3);
    checkOutput("after_to_result", 32'($unsigned(rsp_result)), 32'h02);
    checkOutput("after_to_flag", 32'(rsp_timeout), 32'd0);
    consumeRsp();

    // alu_valid tied high, three back-to-back commands.
    $display("[TB] scenario: valid tied high");
    base = rsp_seen;
    rsp_ops.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'(5 + i);
      cmd_a     = 4'(i + 1);
      cmd_b     = 4'sd3;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    waitIdle();
    rsp_ready = 1'b0;
    checkOutput("tied_rsp_count", 32'(rsp_seen - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < rsp_ops.size()) checkOutput("tied_rsp_order", 32'(rsp_ops[i]), 32'(5 + i));
    end

    // Back-pressure: six offers against a stalled response.
    $display("[TB] scenario: full FIFO");
    base = rsp_seen;
    rsp_ops.delete();
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'(i);
      cmd_a     = 4'(i);
      cmd_b     = 4'sd1;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    #1;
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("full_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    waitIdle();
    rsp_ready = 1'b0;
    checkOutput("full_rsp_count", 32'(rsp_seen - base), 32'd5);
    checkOutput("full_count_end", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < rsp_ops.size()) checkOutput("full_rsp_order", 32'(rsp_ops[i]), 32'(i));
    end

    // Reset during WAIT with two commands queued.
    $display("[TB] scenario: reset mid-operation");
    alu_mode = ALU_NEVER;
    base = rsp_seen;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      cmd_a     = 4'(i + 1);
      cmd_b     = 4'sd2;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("mid_count", 32'(count), 32'd2);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("mid_rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("mid_rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_op", 32'(rsp_op), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    alu_mode = ALU_ALWAYS;
    repeat (4) @(negedge clk);
    checkOutput("mid_no_rsp", 32'(rsp_seen - base), 32'd0);
    applyStimulus(3'b001, 4'sd7, 4'sd2);
    waitRsp(edges);
    checkOutput("mid_after_edges", 32'(edges), 32'd3);
    checkOutput("mid_after_result", 32'($unsigned(rsp_result)), 32'h05);
    consumeRsp();

    // Randomized traffic with one reset pulse in the middle.
    $display("[TB] scenario: random traffic");
    alu_mode = ALU_RANDOM;
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    waitIdle();
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning operand width, matching the downstream ALU.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum WAIT cycles before a command is abandoned.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_op (input, 3), cmd_a (input, N, signed) and cmd_b (input, N, signed): the command push interface.
REQ-007 The block SHALL have ports alu_op (output, 3), alu_a (output, N) and alu_b (output, N): the registered operands driven to the ALU.
REQ-008 The block SHALL have ports alu_result (input, 2N, signed) and alu_valid (input, 1): the ALU result and its valid flag.
REQ-009 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_result (output, 2N, signed), rsp_op (output, 3) and rsp_timeout (output, 1): the response interface.
REQ-010 The block SHALL have ports busy (output, 1), meaning the FSM is not in IDLE, and count (output, clog2(DEPTH+1) bits), meaning FIFO occupancy.

Function
REQ-011 A command SHALL be pushed on a rising edge where cmd_valid and cmd_ready are both high, with cmd_ready = (count < DEPTH) and independent of any same-cycle pop.
REQ-012 The FIFO SHALL preserve order, have no bypass path, and wrap its read and write pointers modulo DEPTH.
REQ-013 A simultaneous push and pop SHALL leave count unchanged.
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-015 In IDLE with count > 0, the FSM SHALL pop the head entry into alu_op, alu_a and alu_b, and go to ISSUE.
REQ-016 ISSUE SHALL last exactly one cycle, SHALL ignore alu_valid (guarding against a stale valid from the previous op), SHALL clear the WAIT timer, and SHALL go to WAIT.
REQ-017 In WAIT with alu_valid high, the FSM SHALL set rsp_result = alu_result, rsp_op = alu_op and rsp_timeout = 0, and go to RESP.
REQ-018 In WAIT with alu_valid low, the timer SHALL increment; when it reaches TIMEOUT-1, the FSM SHALL set rsp_result = 0, rsp_op = alu_op and rsp_timeout = 1, and go to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_result, rsp_op and rsp_timeout SHALL be held stable; on rsp_ready high the FSM SHALL go to IDLE.
REQ-020 alu_op, alu_a and alu_b SHALL change only on a pop and SHALL hold their last values in IDLE.
REQ-021 The minimum latency SHALL be rsp_valid high after the 3rd rising edge following the push edge, given an empty FIFO, IDLE state, and alu_valid high during the first WAIT cycle.
REQ-022 Each popped command SHALL produce exactly one response.
REQ-023 With the FIFO empty, the FSM SHALL stay in IDLE and SHALL NOT issue.

Reset
REQ-024 While rst is low, the block SHALL immediately clear all state: FIFO empty, pointers 0, count = 0, FSM in IDLE, timer = 0.
REQ-025 While rst is low, the outputs SHALL be alu_op = alu_a = alu_b = 0, rsp_valid = 0, rsp_result = 0, rsp_op = 0, rsp_timeout = 0, busy = 0 and cmd_ready = 1.
REQ-026 A reset asserted mid-operation SHALL discard the in-flight command and all queued commands without producing a response.
REQ-027 After rst rises, the first command SHALL be handled per REQ-021.

Verification
REQ-028 The bench SHALL cover this scenario: N=4, push op=000, a=3, b=2; ALU model asserts alu_valid with result 5 in the first WAIT cycle -> rsp_valid after the 3rd edge, rsp_result = 5, rsp_op = 000, rsp_timeout = 0.
REQ-029 The bench SHALL cover this scenario: push op=010, a=-3, b=-2; ALU asserts alu_valid after 4 WAIT cycles with result 6 -> rsp_result = 8'h06, exactly one response.
REQ-030 The bench SHALL cover this scenario: DEPTH=4, rsp_ready=0, offer 6 commands -> 5 accepted (1 in flight, 4 queued), count = 4, cmd_ready = 0; then rsp_ready=1 -> 5 responses in push order, count returns to 0.
REQ-031 The bench SHALL cover this scenario: TIMEOUT=16, alu_valid held at 0 -> RESP entered after 16 WAIT cycles with rsp_timeout = 1 and rsp_result = 0; the next command then completes normally.
REQ-032 The bench SHALL cover this scenario: alu_valid tied to 1, push 3 commands -> exactly 3 responses, none captured during ISSUE.
REQ-033 The bench SHALL cover this scenario: assert rst low during WAIT with 2 commands queued -> outputs at reset values within the same cycle, count = 0, no response; the next push completes per REQ-021.
